countdown_timer_r0: RTL and testbench
=====================================

// Module: countdown_timer_r0
// PURPOSE
//   Loadable down-counting timer; mirror of the up-counter. Loads a start value,
//   decrements at a prescaled rate and pulses done on reaching zero. Used by
//   control logic for wait states, timeouts and periodic events.
// PARAMETERS
//   MAX_COUNT  100                  largest loadable value; larger dataIn saturates to it
//   BIT_WIDTH  log2(MAX_COUNT)      width of dataIn/count; must hold MAX_COUNT
//   DELAY      0                    extra clk cycles per decrement; step every DELAY+1 clks
// PORTS
//   clk     in   1          system clock, rising edge
//   rst     in   1          asynchronous, active-high reset
//   start   in   1          load dataIn and begin counting (level, sampled each edge)
//   pause   in   1          hold count and prescaler while high
//   abort   in   1          return to IDLE immediately, no done pulse
//   dataIn  in   BIT_WIDTH  start value
//   count   out  BIT_WIDTH  current remaining count
//   busy    out  1          high in RUN and HOLD
//   done    out  1          one-cycle pulse on terminal count
// BEHAVIOUR
//   - Reset: state=IDLE, count=0, busy=0, done=0, prescaler=0, reload reg=0.
//   - States: IDLE, RUN, HOLD, DONE. Outputs are registered.
//   - Priority per edge: abort > start > pause > decrement.
//   - abort (any state): ->IDLE, count=0, prescaler=0, busy=0, done=0.
//   - start (any state, incl. RUN/HOLD = restart): count<=sat(dataIn), prescaler<=0,
//     reload reg<=sat(dataIn); sat(x)=MAX_COUNT if x>MAX_COUNT. Next state RUN,
//     or HOLD if pause also high. sat(dataIn)==0 -> DONE (done pulses next cycle,
//     busy stays 0).
//   - RUN: prescaler increments 0..DELAY; at DELAY it clears and count decrements.
//     pause high -> HOLD (count, prescaler frozen); pause low in HOLD -> RUN.
//   - Terminal: the decrement taking count 1->0 moves to DONE; in that cycle
//     count=0, done=1, busy=0. DONE -> IDLE on next edge (done lasts 1 cycle).
//   - Latency: start sampled at edge k with value N>0 -> count=N after edge k;
//     done high after edge k+N*(DELAY+1).
//   - count never underflows: no decrement in IDLE/DONE/HOLD or at count=0.
//   - Inputs ignored in IDLE except start/abort; count holds 0 in IDLE.
//   - rst mid-count: immediate return to reset values, no done pulse.
// CONFIGURATION
//   AUTO_RELOAD_EN defined: at terminal, count<=reload reg and state stays RUN;
//     done pulses for one cycle each period, busy stays 1, count never shows 0
//     (period = reload*(DELAY+1) clks). Stops only via abort, rst, or start with
//     dataIn=0. A reload reg of 0 never enters RUN.
//   AUTO_RELOAD_EN undefined: one-shot as above; reload reg is not built.
// TESTING
//   1 rst held 10 clks -> count=0, busy=0, done=0; release -> all remain 0.
//   2 DELAY=0, start pulse with dataIn=5 -> count 5,4,3,2,1,0 on successive clks;
//     done=1 exactly once with count=0; busy 1 for 5 clks then 0.
//   3 DELAY=2, dataIn=3 -> count steps every 3 clks; done 9 clks after load.
//   4 dataIn=150 (MAX_COUNT=100) -> count loads 100; dataIn=0 -> done next clk,
//     busy never 1.
//   5 dataIn=10, pause high 4 clks at count=6 -> count holds 6, busy=1; resume
//     -> done 6 clks later; start during RUN at count=3 with dataIn=8 -> reloads 8.
//   6 abort at count=4 -> IDLE, count=0, no done; AUTO_RELOAD_EN, dataIn=4 ->
//     done every 4 clks, count 4,3,2,1,4,... until abort.

Source files
------------

// File: rtl/countdown_timer_r0.sv
// Loadable prescaled down-counter; done pulses on reaching zero; AUTO_RELOAD_EN makes it periodic.
// Latency: count=N one clk after start, done N*(DELAY+1) clks after load; all outputs registered.
// No backpressure: pause freezes count/prescaler, abort clears, start (re)loads at any time.
module countdown_timer_r0 #(
    parameter int MAX_COUNT = 100,
    parameter int BIT_WIDTH = $clog2(MAX_COUNT + 1),
    parameter int DELAY     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 abort,
    input  logic [BIT_WIDTH-1:0] dataIn,
    output logic [BIT_WIDTH-1:0] count,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
    localparam logic [PW-1:0]        PRE_MAX = PW'(DELAY);
    localparam logic [BIT_WIDTH-1:0] MAX_VAL = BIT_WIDTH'(MAX_COUNT);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t               state, state_nx;
    logic [BIT_WIDTH-1:0] count_nx;
    logic [BIT_WIDTH-1:0] load_val;
    logic [PW-1:0]        pre, pre_nx;
    logic                 busy_nx, done_nx;
`ifdef AUTO_RELOAD_EN
    logic [BIT_WIDTH-1:0] reload, reload_nx;
`endif

    assign load_val = (dataIn > MAX_VAL) ? MAX_VAL : dataIn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            pre    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            pre    <= pre_nx;
            busy   <= busy_nx;
            done   <= done_nx;
`ifdef AUTO_RELOAD_EN
            reload <= reload_nx;
`endif
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        pre_nx    = pre;
        done_nx   = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_nx = reload;
`endif
        if (abort) begin
            state_nx = IDLE;
            count_nx = '0;
            pre_nx   = '0;
        end else if (start) begin
            count_nx = load_val;
            pre_nx   = '0;
`ifdef AUTO_RELOAD_EN
            reload_nx = load_val;
`endif
            if (load_val == '0)
                state_nx = DONE;
            else if (pause)
                state_nx = HOLD;
            else
                state_nx = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (pause) begin
                        state_nx = HOLD;
                    end else if (pre == PRE_MAX) begin
                        pre_nx = '0;
                        if (count > 1) begin
                            count_nx = count - 1'b1;
                        end else begin
`ifdef AUTO_RELOAD_EN
                            // reload is nonzero whenever RUN is reachable
                            count_nx = reload;
                            done_nx  = 1'b1;
`else
                            count_nx = '0;
                            state_nx = DONE;
`endif
                        end
                    end else begin
                        pre_nx = pre + PW'(1);
                    end
                end
                HOLD: begin
                    if (!pause)
                        state_nx = RUN;
                end
                DONE: state_nx = IDLE;
                default: ;
            endcase
        end
        if (state_nx == DONE)
            done_nx = 1'b1;
        busy_nx = (state_nx == RUN) || (state_nx == HOLD);
    end

endmodule

// File: tb/tb_countdown_timer_r0.sv
// Directed and random bench for countdown_timer_r0 with DELAY=0 and DELAY=2 instances
// checked every cycle against an elapsed-time arithmetic model.
module tb_countdown_timer_r0;
    localparam int MAXC = 100;
    localparam int BW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [BW-1:0] dataIn = '0;
    logic [BW-1:0] count0, count2;
    logic          busy0, busy2, done0, done2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    countdown_timer_r0 #(.MAX_COUNT(MAXC), .BIT_WIDTH(BW), .DELAY(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .dataIn(dataIn), .count(count0), .busy(busy0), .done(done0));

    countdown_timer_r0 #(.MAX_COUNT(MAXC), .BIT_WIDTH(BW), .DELAY(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .dataIn(dataIn), .count(count2), .busy(busy2), .done(done2));

    // Model: loaded value N and elapsed running cycles e; count = N - e/(DELAY+1)
    int dly[2] = '{0, 2};
    bit m_act[2], m_hold[2], m_done[2];
    int m_n[2], m_e[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_hold[i] = 0; m_done[i] = 0; m_n[i] = 0; m_e[i] = 0;
        end
    endtask

    task automatic model_step(input bit ab, input bit st, input bit pa, input int din);
        int n;
        n = din & 255;
        if (n > MAXC) n = MAXC;
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 0;
            if (ab) begin
                m_act[i] = 0; m_hold[i] = 0; m_n[i] = 0; m_e[i] = 0;
            end else if (st) begin
                m_n[i] = n; m_e[i] = 0; m_hold[i] = pa;
                m_act[i] = (n > 0);
                m_done[i] = (n == 0);
            end else if (m_act[i]) begin
                if (m_hold[i]) begin
                    m_hold[i] = pa;
                end else if (pa) begin
                    m_hold[i] = 1;
                end else begin
                    m_e[i]++;
                    if (m_e[i] == m_n[i] * (dly[i] + 1)) begin
                        m_done[i] = 1;
`ifdef AUTO_RELOAD_EN
                        m_e[i] = 0;
`else
                        m_act[i] = 0;
`endif
                    end
                end
            end
        end
    endtask

    function automatic int exp_count(input int i);
        return m_act[i] ? m_n[i] - m_e[i] / (dly[i] + 1) : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/count0"}, 32'(count0), exp_count(0));
        chk({tag, "/busy0"},  32'(busy0),  32'(m_act[0]));
        chk({tag, "/done0"},  32'(done0),  32'(m_done[0]));
        chk({tag, "/count2"}, 32'(count2), exp_count(1));
        chk({tag, "/busy2"},  32'(busy2),  32'(m_act[1]));
        chk({tag, "/done2"},  32'(done2),  32'(m_done[1]));
    endtask

    task automatic cyc(input bit ab, input bit st, input bit pa, input int din, input string tag);
        @(negedge clk);
        abort = ab; start = st; pause = pa; dataIn = BW'(din);
        @(posedge clk);
        model_step(ab, st, pa, din);
        #1;
        check_all(tag);
    endtask

    initial begin
        int dcnt;
        int first;
        model_reset();

        // 1: reset held, then released
        repeat (10) begin
            @(posedge clk); #1;
            check_all("reset");
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cyc(0, 0, 1, 7, "idle");

        // 2: DELAY=0, load 5
        cyc(0, 1, 0, 5, "t2_load");
        chk("t2_load_val", 32'(count0), 5);
        chk("t2_load_busy", 32'(busy0), 1);
        dcnt = 0;
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 0, 0, "t2_run");
            dcnt += int'(done0);
        end
        chk("t2_done_once", dcnt, 1);
        chk("t2_done_last", 32'(done0), 1);
`ifdef AUTO_RELOAD_EN
        chk("t2_reload", 32'(count0), 5);
`else
        chk("t2_end_count", 32'(count0), 0);
        chk("t2_end_busy", 32'(busy0), 0);
`endif
        cyc(1, 0, 0, 0, "abort");

        // 3: DELAY=2, load 3 -> done 9 clks after load
        cyc(0, 1, 0, 3, "t3_load");
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 0, "t3_run");
            if (k == 3) chk("t3_step", 32'(count2), 2);
            if (done2 && first < 0) first = k;
        end
        chk("t3_done_at", first, 9);
        cyc(1, 0, 0, 0, "abort");

        // 4: saturation and zero load
        cyc(0, 1, 0, 150, "t4_sat");
        chk("t4_sat0", 32'(count0), MAXC);
        chk("t4_sat2", 32'(count2), MAXC);
        cyc(0, 1, 0, 0, "t4_zero");
        chk("t4_zero_done", 32'(done0), 1);
        chk("t4_zero_busy", 32'(busy0), 0);
        cyc(0, 0, 0, 0, "t4_after");
        chk("t4_after_done", 32'(done0), 0);

        // 5: pause at count 6, resume, then restart mid-run
        cyc(0, 1, 0, 10, "t5_load");
        repeat (4) cyc(0, 0, 0, 0, "t5_run");
        chk("t5_at6", 32'(count0), 6);
        repeat (4) begin
            cyc(0, 0, 1, 0, "t5_hold");
            chk("t5_hold_cnt", 32'(count0), 6);
            chk("t5_hold_busy", 32'(busy0), 1);
        end
        cyc(0, 0, 0, 0, "t5_resume");
        first = -1;
        for (int k = 1; k <= 7; k++) begin
            cyc(0, 0, 0, 0, "t5_tail");
            if (done0 && first < 0) first = k;
        end
        chk("t5_done_at", first, 6);
        cyc(0, 1, 0, 10, "t5_reload");
        repeat (7) cyc(0, 0, 0, 0, "t5_run2");
        chk("t5_at3", 32'(count0), 3);
        cyc(0, 1, 0, 8, "t5_restart");
        chk("t5_restart_val", 32'(count0), 8);

        // 6: abort mid-count
        cyc(0, 1, 0, 10, "t6_load");
        repeat (6) cyc(0, 0, 0, 0, "t6_run");
        chk("t6_at4", 32'(count0), 4);
        cyc(1, 0, 0, 0, "t6_abort");
        chk("t6_abort_cnt", 32'(count0), 0);
        chk("t6_abort_busy", 32'(busy0), 0);
        chk("t6_abort_done", 32'(done0), 0);
`ifdef AUTO_RELOAD_EN
        cyc(0, 1, 0, 4, "t6_auto_load");
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 0, 0, 0, "t6_auto");
            chk("t6_auto_cnt", 32'(count0), 4 - (k % 4));
            chk("t6_auto_done", 32'(done0), 32'((k % 4) == 0));
            chk("t6_auto_busy", 32'(busy0), 1);
        end
        cyc(1, 0, 0, 0, "t6_auto_abort");
`endif

        // rst mid-count: immediate clear, no done afterwards
        cyc(0, 1, 0, 20, "rst_load");
        repeat (3) cyc(0, 0, 0, 0, "rst_run");
        @(negedge clk);
        rst = 1'b1;
        #2;
        model_reset();
        check_all("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 0, "rst_after");

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            bit ab, st, pa;
            int din;
            ab = ($urandom % 40) == 0;
            st = ($urandom % 12) == 0;
            pa = ($urandom % 5) == 0;
            din = (($urandom % 4) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            cyc(ab, st, pa, din, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
